volume_level_ctrl: RTL

- Converts the 12-bit microphone sample stream into the 16-bit thermometer level code (`tester`) that drives the soundbar display, plus the 2-bit colour-theme select (`R`).
- Per window: tracks the peak, quantizes it to 0..16, then applies peak-hold and a 1-level-per-window decay.
- Sits between the mic capture block and the soundbar renderer.
- Supports display freeze and theme cycling.

---
 rtl/volume_level_ctrl_pkg.sv | 31 +++
 rtl/volume_level_ctrl_if.sv | 25 ++
 rtl/volume_level_ctrl_peak_window.sv | 60 ++++++
 rtl/volume_level_ctrl.sv | 103 ++++++++++
 4 files changed

// File: rtl/volume_level_ctrl_pkg.sv
// Shared types and helpers for the soundbar level path: level/tester widths,
// theme codes and the level-to-thermometer encoder used by RTL and renderer benches.
package volume_level_ctrl_pkg;

  localparam int LEVEL_MAX = 16;
  localparam int LEVEL_W   = 5;
  localparam int TESTER_W  = 16;
  localparam int SAMPLE_W  = 12;

  typedef logic [LEVEL_W-1:0]  level_t;
  typedef logic [TESTER_W-1:0] tester_t;

  typedef enum logic [1:0] {
    THEME_0 = 2'd0,
    THEME_1 = 2'd1,
    THEME_2 = 2'd2,
    THEME_3 = 2'd3
  } theme_t;

  // Levels above LEVEL_MAX saturate so only legal thermometer codes can appear
  function automatic tester_t thermo_encode(input level_t lvl);
    logic [TESTER_W:0] code_s;
    if (lvl >= LEVEL_W'(LEVEL_MAX)) begin
      code_s = {1'b0, {TESTER_W{1'b1}}};
    end else begin
      code_s = (17'd1 << lvl) - 17'd1;
    end
    return code_s[TESTER_W-1:0];
  endfunction

endpackage

// File: rtl/volume_level_ctrl_if.sv
// Sample/control/display bundle between mic capture, the level controller and
// the soundbar renderer.
interface volume_level_ctrl_if;
  import volume_level_ctrl_pkg::*;

  logic [SAMPLE_W-1:0] mic_in;
  logic                sample_valid;
  logic                freeze;
  logic                theme_btn;
  tester_t             tester;
  level_t              level;
  logic [1:0]          R;
  logic                frame_tick;

  modport master (
    output mic_in, sample_valid, freeze, theme_btn,
    input  tester, level, R, frame_tick
  );

  modport slave (
    input  mic_in, sample_valid, freeze, theme_btn,
    output tester, level, R, frame_tick
  );

endinterface

// File: rtl/volume_level_ctrl_peak_window.sv
// Counts WINDOW samples and tracks their maximum; publishes the window peak
// with a one-cycle window_done on the edge that takes the closing sample.
module volume_level_ctrl_peak_window
  import volume_level_ctrl_pkg::*;
#(
  parameter int WINDOW = 4000
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [SAMPLE_W-1:0] mic_in,
  input  logic                sample_valid,
  output logic [SAMPLE_W-1:0] peak_final,
  output logic                window_done
);

  localparam int CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(WINDOW - 1);

  logic [CNT_W-1:0]    count_r;
  logic [SAMPLE_W-1:0] peak_r;
  logic [SAMPLE_W-1:0] peak_final_r;
  logic                done_r;
  logic [SAMPLE_W-1:0] sample_max_s;

  // Running maximum including the sample currently presented
  always_comb begin
    if (mic_in > peak_r) begin
      sample_max_s = mic_in;
    end else begin
      sample_max_s = peak_r;
    end
  end

  // Counter and peak tracker; the closing sample is folded into the closing window
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_r      <= {CNT_W{1'b0}};
      peak_r       <= {SAMPLE_W{1'b0}};
      peak_final_r <= {SAMPLE_W{1'b0}};
      done_r       <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (sample_valid) begin
        if (count_r == LAST_C) begin
          peak_final_r <= sample_max_s;
          count_r      <= {CNT_W{1'b0}};
          peak_r       <= {SAMPLE_W{1'b0}};
          done_r       <= 1'b1;
        end else begin
          count_r <= count_r + CNT_W'(1);
          peak_r  <= sample_max_s;
        end
      end
    end
  end

  assign peak_final  = peak_final_r;
  assign window_done = done_r;

endmodule

// File: rtl/volume_level_ctrl.sv
// Soundbar level controller: quantizes each window peak to 0..16, applies
// peak-hold and one-step decay, and drives the thermometer code plus theme select.
module volume_level_ctrl
  import volume_level_ctrl_pkg::*;
#(
  parameter int WINDOW       = 4000,
  parameter int BASELINE     = 2048,
  parameter int SHIFT        = 7,
  parameter int HOLD_WINDOWS = 2
) (
  input  logic               clock,
  input  logic               reset_n,
  volume_level_ctrl_if.slave bus
);

  localparam int HOLD_W = (HOLD_WINDOWS > 0) ? $clog2(HOLD_WINDOWS + 1) : 1;
  localparam logic [HOLD_W-1:0]   HOLD_RELOAD_C = HOLD_W'(HOLD_WINDOWS);
  localparam logic [SAMPLE_W-1:0] BASE_C        = SAMPLE_W'(BASELINE);

  logic [SAMPLE_W-1:0] peak_final_s;
  logic                window_done_s;
  logic [SAMPLE_W-1:0] amp_s;
  logic [SAMPLE_W:0]   steps_s;
  level_t              raw_s;

  level_t              level_r, level_nxt_s;
  tester_t             tester_r;
  logic [HOLD_W-1:0]   hold_r, hold_nxt_s;
  logic                tick_r, tick_nxt_s;
  logic [1:0]          theme_r;

  volume_level_ctrl_peak_window #(.WINDOW(WINDOW)) u_peak_window (
    .clock       (clock),
    .reset_n     (reset_n),
    .mic_in      (bus.mic_in),
    .sample_valid(bus.sample_valid),
    .peak_final  (peak_final_s),
    .window_done (window_done_s)
  );

  // Peak to raw level: any amplitude above baseline lights at least one segment
  always_comb begin
    amp_s = {SAMPLE_W{1'b0}};
    if (peak_final_s > BASE_C) begin
      amp_s = peak_final_s - BASE_C;
    end else begin
      amp_s = {SAMPLE_W{1'b0}};
    end
    steps_s = {1'b0, amp_s >> SHIFT} + {{SAMPLE_W{1'b0}}, (amp_s != {SAMPLE_W{1'b0}})};
    if (steps_s >= (SAMPLE_W+1)'(LEVEL_MAX)) begin
      raw_s = LEVEL_W'(LEVEL_MAX);
    end else begin
      raw_s = steps_s[LEVEL_W-1:0];
    end
  end

  // Hold/decay next state, evaluated only on the cycle after a window closes
  always_comb begin
    level_nxt_s = level_r;
    hold_nxt_s  = hold_r;
    tick_nxt_s  = 1'b0;
    if (window_done_s && !bus.freeze) begin
      tick_nxt_s = 1'b1;
      if (raw_s >= level_r) begin
        level_nxt_s = raw_s;
        hold_nxt_s  = HOLD_RELOAD_C;
      end else if (hold_r != {HOLD_W{1'b0}}) begin
        hold_nxt_s = hold_r - HOLD_W'(1);
      end else begin
        level_nxt_s = level_r - LEVEL_W'(1);
      end
    end else begin
      tick_nxt_s = 1'b0;
    end
  end

  // Display registers; tester is encoded from the same next level so both move together
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      level_r  <= {LEVEL_W{1'b0}};
      tester_r <= {TESTER_W{1'b0}};
      hold_r   <= {HOLD_W{1'b0}};
      tick_r   <= 1'b0;
      theme_r  <= THEME_0;
    end else begin
      level_r  <= level_nxt_s;
      tester_r <= thermo_encode(level_nxt_s);
      hold_r   <= hold_nxt_s;
      tick_r   <= tick_nxt_s;
      if (bus.theme_btn) begin
        theme_r <= theme_r + 2'd1;
      end else begin
        theme_r <= theme_r;
      end
    end
  end

  assign bus.level      = level_r;
  assign bus.tester     = tester_r;
  assign bus.frame_tick = tick_r;
  assign bus.R          = theme_r;

endmodule
